// File: rtl/npc_pkg.sv
// Shared types, switch patterns and state decoder for the NPC gate generator.
package npc_pkg;

    typedef enum logic [1:0] {
        LVL_N   = 2'd0,
        LVL_O   = 2'd1,
        LVL_P   = 2'd2,
        LVL_OFF = 2'd3
    } level_e;

    typedef struct packed {
        level_e a;
        level_e b;
        level_e c;
    } leg_levels_t;

    // Gate patterns, bit3=S1 (outer top) .. bit0=S4 (outer bottom)
    localparam logic [3:0] PAT_P        = 4'b1100;
    localparam logic [3:0] PAT_O        = 4'b0110;
    localparam logic [3:0] PAT_N        = 4'b0011;
    localparam logic [3:0] PAT_OFF      = 4'b0000;
    localparam logic [3:0] PAT_BLANK_PO = 4'b0100;  // between P and O, only S2 on
    localparam logic [3:0] PAT_BLANK_ON = 4'b0010;  // between O and N, only S3 on

    localparam int DT_CYCLES_DEF = 2;

    // Highest valid switching-state index (PPP)
    localparam logic [4:0] STATE_MAX = 5'd26;

    function automatic logic [3:0] level_pattern(input level_e lvl);
        case (lvl)
            LVL_P:   return PAT_P;
            LVL_O:   return PAT_O;
            LVL_N:   return PAT_N;
            default: return PAT_OFF;
        endcase
    endfunction

    // state = 9*La + 3*Lb + Lc, done with compares instead of dividers
    function automatic leg_levels_t decode_state(input logic [4:0] s);
        leg_levels_t d;
        logic [1:0]  la;
        logic [1:0]  lb;
        logic [4:0]  rem;
        if (s >= 5'd18)      la = 2'd2;
        else if (s >= 5'd9)  la = 2'd1;
        else                 la = 2'd0;
        rem = s - 5'(la) * 5'd9;
        if (rem >= 5'd6)     lb = 2'd2;
        else if (rem >= 5'd3) lb = 2'd1;
        else                 lb = 2'd0;
        d.a = level_e'(la);
        d.b = level_e'(lb);
        d.c = level_e'(2'(rem - 5'(lb) * 5'd3));
        return d;
    endfunction

endpackage

// File: rtl/npc_leg.sv
// One NPC leg: level FSM with dead-time blanking, adjacent-level steps only.
import npc_pkg::*;

module npc_leg #(
    parameter int DT_CYCLES = DT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  level_e     target,
    output logic [3:0] gate
);

    localparam int CW = (DT_CYCLES > 1) ? $clog2(DT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DT_CYCLES - 1);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_P     = 3'd1;
    localparam logic [2:0] ST_O     = 3'd2;
    localparam logic [2:0] ST_N     = 3'd3;
    localparam logic [2:0] ST_BLANK = 3'd4;

    logic [2:0]    st_reg,   st_next;
    logic [CW-1:0] cnt_reg,  cnt_next;
    level_e        dest_reg, dest_next;
    logic [3:0]    gate_reg, gate_next;

    // Next state; the gate pattern is computed alongside so it is registered with the state
    always_comb begin
        st_next   = st_reg;
        cnt_next  = cnt_reg;
        dest_next = dest_reg;
        gate_next = gate_reg;
        case (st_reg)
            ST_OFF: begin
                // Post-reset wait, then always enter at O and step from there
                if (cnt_reg == '0) begin
                    st_next   = ST_O;
                    gate_next = PAT_O;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_P: begin
                if (target == LVL_O || target == LVL_N) begin
                    st_next   = ST_BLANK;
                    dest_next = LVL_O;
                    cnt_next  = CNT_LOAD;
                    gate_next = PAT_BLANK_PO;
                end
            end
            ST_N: begin
                if (target == LVL_O || target == LVL_P) begin
                    st_next   = ST_BLANK;
                    dest_next = LVL_O;
                    cnt_next  = CNT_LOAD;
                    gate_next = PAT_BLANK_ON;
                end
            end
            ST_O: begin
                if (target == LVL_P) begin
                    st_next   = ST_BLANK;
                    dest_next = LVL_P;
                    cnt_next  = CNT_LOAD;
                    gate_next = PAT_BLANK_PO;
                end else if (target == LVL_N) begin
                    st_next   = ST_BLANK;
                    dest_next = LVL_N;
                    cnt_next  = CNT_LOAD;
                    gate_next = PAT_BLANK_ON;
                end
            end
            ST_BLANK: begin
                // Target is ignored here: the step in progress always completes
                if (cnt_reg == '0) begin
                    gate_next = level_pattern(dest_reg);
                    case (dest_reg)
                        LVL_P:   st_next = ST_P;
                        LVL_N:   st_next = ST_N;
                        default: st_next = ST_O;
                    endcase
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                st_next   = ST_OFF;
                cnt_next  = CNT_LOAD;
                gate_next = PAT_OFF;
            end
        endcase
    end

    // State registers; reset forces all switches off at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg   <= ST_OFF;
            cnt_reg  <= CNT_LOAD;
            dest_reg <= LVL_O;
            gate_reg <= PAT_OFF;
        end else begin
            st_reg   <= st_next;
            cnt_reg  <= cnt_next;
            dest_reg <= dest_next;
            gate_reg <= gate_next;
        end
    end

    assign gate = gate_reg;

endmodule

// File: rtl/npc_deadtime.sv
// Three-level NPC gate generator: registers the state index, decodes it, drives three legs.
import npc_pkg::*;

module npc_deadtime #(
    parameter int DT_CYCLES = DT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] state,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic [3:0] out_c
);

    logic [4:0]  state_q;
    leg_levels_t lvls;
    level_e      leg_tgt  [3];
    logic [3:0]  leg_gate [3];

    // Capture only valid codes, so an invalid index leaves every leg's target untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 5'd13;
        end else if (state <= STATE_MAX) begin
            state_q <= state;
        end
    end

    assign lvls       = decode_state(state_q);
    assign leg_tgt[0] = lvls.a;
    assign leg_tgt[1] = lvls.b;
    assign leg_tgt[2] = lvls.c;

    for (genvar gi = 0; gi < 3; gi++) begin : g_leg
        npc_leg #(
            .DT_CYCLES (DT_CYCLES)
        ) u_leg (
            .clk    (clk),
            .rst    (rst),
            .target (leg_tgt[gi]),
            .gate   (leg_gate[gi])
        );
    end

    assign out_a = leg_gate[0];
    assign out_b = leg_gate[1];
    assign out_c = leg_gate[2];

endmodule

// File: tb/tb_npc_deadtime.sv
// Directed-vector bench for npc_deadtime with DT_CYCLES = 2.
module tb_npc_deadtime;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] state = 5'd13;
    logic [3:0] out_a, out_b, out_c;

    int vectors = 0;
    int miscompares = 0;

    npc_deadtime #(
        .DT_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .out_a (out_a),
        .out_b (out_b),
        .out_c (out_c)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [4:0] s);
        state = s;
        repeat (20) tick();
    endtask

    function automatic logic [3:0] exp_pat(input int lvl);
        case (lvl)
            2:       return 4'b1100;
            1:       return 4'b0110;
            default: return 4'b0011;
        endcase
    endfunction

    task automatic test_reset();
        logic [3:0] seq [6];
        seq[0] = 4'b0000; seq[1] = 4'b0110; seq[2] = 4'b0100;
        seq[3] = 4'b0100; seq[4] = 4'b1100; seq[5] = 4'b1100;
        #3;
        vectors++;
        if ({out_a, out_b, out_c} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_initial: got %h expected 000", {out_a, out_b, out_c});
        end
        @(posedge clk);
        #1;
        state = 5'd26;
        rst   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== {3{seq[i]}}) begin
                miscompares++;
                $display("FAIL reset_release[%0d]: got %h expected %h", i, {out_a, out_b, out_c}, {3{seq[i]}});
            end
        end
        // Asynchronous assertion mid-cycle from the settled P state
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_a, out_b, out_c} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected 000", {out_a, out_b, out_c});
        end
        tick();
        vectors++;
        if ({out_a, out_b, out_c} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected 000", {out_a, out_b, out_c});
        end
        rst = 1'b0;
        settle(5'd26);
        vectors++;
        if ({out_a, out_b, out_c} !== 12'hccc) begin
            miscompares++;
            $display("FAIL reset_resettle: got %h expected ccc", {out_a, out_b, out_c});
        end
    endtask

    task automatic test_step_down();
        logic [3:0] seq [4];
        seq[0] = 4'b0110; seq[1] = 4'b0010; seq[2] = 4'b0010; seq[3] = 4'b0011;
        settle(5'd13);
        vectors++;
        if ({out_a, out_b, out_c} !== 12'h666) begin
            miscompares++;
            $display("FAIL step_settle13: got %h expected 666", {out_a, out_b, out_c});
        end
        state = 5'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== {3{seq[i]}}) begin
                miscompares++;
                $display("FAIL step_13_to_0[k+%0d]: got %h expected %h", i, {out_a, out_b, out_c}, {3{seq[i]}});
            end
        end
    endtask

    task automatic test_full_swing();
        logic [3:0] seq [8];
        seq[0] = 4'b1100; seq[1] = 4'b0100; seq[2] = 4'b0100; seq[3] = 4'b0110;
        seq[4] = 4'b0010; seq[5] = 4'b0010; seq[6] = 4'b0011; seq[7] = 4'b0011;
        settle(5'd26);
        state = 5'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== {3{seq[i]}}) begin
                miscompares++;
                $display("FAIL swing_26_to_0[k+%0d]: got %h expected %h", i, {out_a, out_b, out_c}, {3{seq[i]}});
            end
        end
    endtask

    task automatic test_mid_blank_change();
        logic [3:0] seq [8];
        seq[0] = 4'b0110; seq[1] = 4'b0100; seq[2] = 4'b0100; seq[3] = 4'b1100;
        seq[4] = 4'b0100; seq[5] = 4'b0100; seq[6] = 4'b0110; seq[7] = 4'b0110;
        settle(5'd13);
        state = 5'd26;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) state = 5'd13;  // leg is in BLANK toward P now
            vectors++;
            if ({out_a, out_b, out_c} !== {3{seq[i]}}) begin
                miscompares++;
                $display("FAIL midblank_change[k+%0d]: got %h expected %h", i, {out_a, out_b, out_c}, {3{seq[i]}});
            end
        end
    endtask

    task automatic test_reset_mid_blank();
        settle(5'd13);
        state = 5'd26;
        tick();
        tick();
        vectors++;
        if ({out_a, out_b, out_c} !== 12'h444) begin
            miscompares++;
            $display("FAIL rstblank_pre: got %h expected 444", {out_a, out_b, out_c});
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_a, out_b, out_c} !== 12'h000) begin
            miscompares++;
            $display("FAIL rstblank_async: got %h expected 000", {out_a, out_b, out_c});
        end
        tick();
        rst = 1'b0;
        settle(5'd26);
        vectors++;
        if ({out_a, out_b, out_c} !== 12'hccc) begin
            miscompares++;
            $display("FAIL rstblank_recover: got %h expected ccc", {out_a, out_b, out_c});
        end
    endtask

    task automatic test_sweep();
        logic [3:0] ea, eb, ec;
        int         bad;
        ea = 4'b1100; eb = 4'b1100; ec = 4'b1100;
        for (int s = 0; s <= 27; s++) begin
            state = 5'(s);
            bad = 0;
            if (s <= 26) begin
                ea = exp_pat(s / 9);
                eb = exp_pat((s / 3) % 3);
                ec = exp_pat(s % 3);
            end
            for (int c = 0; c < 1000; c++) begin
                tick();
                for (int l = 0; l < 3; l++) begin
                    logic [3:0] g;
                    g = (l == 0) ? out_a : (l == 1) ? out_b : out_c;
                    if ((g[3] && g[1]) || (g[2] && g[0]) ||
                        !(g == 4'b0000 || g == 4'b1100 || g == 4'b0100 ||
                          g == 4'b0110 || g == 4'b0010 || g == 4'b0011))
                        bad++;
                end
            end
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("FAIL sweep_legal[state=%0d]: got %0d illegal samples expected 0", s, bad);
            end
            vectors++;
            if ({out_a, out_b, out_c} !== {ea, eb, ec}) begin
                miscompares++;
                $display("FAIL sweep_level[state=%0d]: got %h expected %h", s, {out_a, out_b, out_c}, {ea, eb, ec});
            end
        end
    endtask

    initial begin
        test_reset();
        test_step_down();
        test_full_swing();
        test_mid_blank_change();
        test_reset_mid_blank();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
